// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, Wishbone burst line refill.
// state  | meaning
// IDLE   | lookup on fetch; miss latches the line address and starts a refill
// REFILL | burst-reading one line, stall held high
// ERR    | refill failed; bus_err shown until the core moves off that line
module inst_cache #(
  parameter int LINE_WORDS_WIDTH = 2,
  parameter int LINE_NUM_WIDTH   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        lock,
  input  logic        inv,
  input  logic [31:0] addr,
  output logic [31:0] dout,
  output logic        stall,
  output logic        unalign,
  output logic        bus_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [31:0] wbm_addr_o,
  input  logic [31:0] wbm_data_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  localparam int OFF_W  = LINE_WORDS_WIDTH + 2;
  localparam int LINE_W = 32 - OFF_W;
  localparam int TAG_W  = LINE_W - LINE_NUM_WIDTH;
  localparam int LINES  = 1 << LINE_NUM_WIDTH;
  localparam int DEPTH  = 1 << (LINE_NUM_WIDTH + LINE_WORDS_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_ERR} state_t;

  state_t                      state_q, state_d;
  logic [LINE_W-1:0]           line_q, line_d;
  logic [LINE_WORDS_WIDTH-1:0] beat_q, beat_d;
  logic                        cyc_q, cyc_d;
  logic                        sup_q, sup_d;
  logic [LINES-1:0]            valid_q, valid_d;
  logic [31:0]                 hold_dout_q, hold_dout_d;
  logic                        hold_stall_q, hold_stall_d;
  logic                        hold_err_q, hold_err_d;

  logic [31:0]      data_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem  [LINES];

  logic [LINE_NUM_WIDTH-1:0]   req_idx, fill_idx;
  logic [TAG_W-1:0]            req_tag, fill_tag;
  logic [LINE_WORDS_WIDTH-1:0] req_word;
  logic                        fetch, hit, last_beat, ack_ok, bus_fail;
  logic [31:0]                 live_dout;
  logic                        live_stall, live_err, idle_locked;

  assign req_idx   = addr[OFF_W +: LINE_NUM_WIDTH];
  assign req_tag   = addr[31 -: TAG_W];
  assign req_word  = addr[2 +: LINE_WORDS_WIDTH];
  assign fill_idx  = line_q[LINE_NUM_WIDTH-1:0];
  assign fill_tag  = line_q[LINE_W-1 -: TAG_W];
  assign fetch     = en && (addr[1:0] == 2'b00);
  assign hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign last_beat = &beat_q;
  // err takes priority over a simultaneous ack
  assign bus_fail  = (state_q == S_REFILL) && wbm_err_i;
  assign ack_ok    = (state_q == S_REFILL) && wbm_ack_i && !wbm_err_i;

  always_comb begin
    live_dout  = 32'h0;
    live_stall = 1'b0;
    live_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fetch && hit) live_dout = data_mem[{req_idx, req_word}];
        live_stall = fetch && !hit;
      end
      S_REFILL: live_stall = 1'b1;
      S_ERR:    live_err   = 1'b1;
      default:  live_stall = 1'b0;
    endcase
  end

  assign idle_locked = (state_q == S_IDLE) && lock;
  assign dout        = idle_locked ? hold_dout_q  : live_dout;
  assign stall       = idle_locked ? hold_stall_q : live_stall;
  assign bus_err     = idle_locked ? hold_err_q   : live_err;
  assign unalign     = en && (addr[1:0] != 2'b00);
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_addr_o  = {line_q, beat_q, 2'b00};

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    beat_d       = beat_q;
    cyc_d        = cyc_q;
    sup_d        = sup_q | inv;
    valid_d      = valid_q;
    hold_dout_d  = lock ? hold_dout_q  : dout;
    hold_stall_d = lock ? hold_stall_q : stall;
    hold_err_d   = lock ? hold_err_q   : bus_err;
    case (state_q)
      S_IDLE: begin
        if (!lock && fetch && !hit) begin
          line_d  = addr[31:OFF_W];
          beat_d  = '0;
          cyc_d   = 1'b1;
          sup_d   = 1'b0;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (bus_fail) begin
          cyc_d   = 1'b0;
          state_d = S_ERR;
        end else if (ack_ok) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            cyc_d   = 1'b0;
            state_d = S_IDLE;
            if (!sup_q && !inv) valid_d[fill_idx] = 1'b1;
          end
        end
      end
      S_ERR: begin
        if (!(lock || (en && (addr[31:OFF_W] == line_q)))) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (inv) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      line_q       <= '0;
      beat_q       <= '0;
      cyc_q        <= 1'b0;
      sup_q        <= 1'b0;
      valid_q      <= '0;
      hold_dout_q  <= 32'h0;
      hold_stall_q <= 1'b0;
      hold_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      beat_q       <= beat_d;
      cyc_q        <= cyc_d;
      sup_q        <= sup_d;
      valid_q      <= valid_d;
      hold_dout_q  <= hold_dout_d;
      hold_stall_q <= hold_stall_d;
      hold_err_q   <= hold_err_d;
    end
  end

  // Arrays carry no reset; valid_q alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (!rst && ack_ok) begin
      data_mem[{fill_idx, beat_q}] <= wbm_data_i;
      if (last_beat) tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: a Wishbone slave model returns base+word per beat,
// with optional alternate-cycle wait states and an error on a chosen beat.
module tb_inst_cache;
  logic        clk, rst, en, lock, inv;
  logic [31:0] addr, dout, wbm_addr_o, wbm_data_i;
  logic        stall, unalign, bus_err, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;

  logic [31:0] slv_base;
  logic        err_en, slow, ack_ph;
  logic [1:0]  err_beat;
  int          n_tests, n_fail, s;

  inst_cache dut (
    .clk(clk), .rst(rst), .en(en), .lock(lock), .inv(inv), .addr(addr),
    .dout(dout), .stall(stall), .unalign(unalign), .bus_err(bus_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_addr_o(wbm_addr_o),
    .wbm_data_i(wbm_data_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    wbm_err_i  = wbm_cyc_o && wbm_stb_o && err_en && (wbm_addr_o[3:2] == err_beat);
    wbm_ack_i  = wbm_cyc_o && wbm_stb_o && !wbm_err_i && (!slow || ack_ph);
    wbm_data_i = slv_base + 32'(wbm_addr_o[3:2]);
  end

  always @(posedge clk) ack_ph <= (wbm_cyc_o === 1'b1) ? ~ack_ph : 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Fetch until stall drops; inv is pulsed in cycle inv_cyc (cycle 0 = miss cycle).
  task automatic fetch(input logic [31:0] a, input int inv_cyc, output int stalls);
    int c;
    c = 0;
    en = 1'b1;
    addr = a;
    #1;
    while (stall && c < 40) begin
      inv = (c == inv_cyc);
      c++;
      step();
      #1;
    end
    inv = 1'b0;
    stalls = c;
    chk("fetch_bound", 32'(c < 40), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; en = 1'b0; lock = 1'b0; inv = 1'b0; addr = 32'h0;
    slv_base = 32'hA0; err_en = 1'b0; err_beat = 2'd0; slow = 1'b0;
    repeat (3) step();
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_cyc", 32'(wbm_cyc_o), 0);
    chk("rst_wbaddr", wbm_addr_o, 0);
    chk("rst_buserr", 32'(bus_err), 0);
    chk("rst_dout", dout, 0);
    rst = 1'b0;
    step();

    // cold miss then hit
    en = 1'b1; addr = 32'h104; #1;
    chk("miss_c0_stall", 32'(stall), 1);
    chk("miss_c0_cyc", 32'(wbm_cyc_o), 0);
    step(); #1;
    for (int k = 0; k < 4; k++) begin
      chk("refill_addr", wbm_addr_o, 32'h100 + 32'(4 * k));
      chk("refill_stall", 32'(stall), 1);
      chk("refill_stb", 32'(wbm_stb_o), 1);
      step(); #1;
    end
    chk("hit_stall", 32'(stall), 0);
    chk("hit_dout", dout, 32'hA1);
    chk("hit_cyc", 32'(wbm_cyc_o), 0);
    addr = 32'h10C; #1;
    chk("hit2_dout", dout, 32'hA3);
    chk("hit2_stall", 32'(stall), 0);
    step(); #1;
    chk("hit2_nobus", 32'(wbm_cyc_o), 0);

    // conflict eviction
    slv_base = 32'hB0;
    fetch(32'h500, -1, s);
    chk("evict_stalls", s, 5);
    chk("evict_dout", dout, 32'hB0);
    slv_base = 32'hC0;
    fetch(32'h100, -1, s);
    chk("refetch_stalls", s, 5);
    chk("refetch_dout", dout, 32'hC0);

    // unaligned
    addr = 32'h102; #1;
    chk("unal_flag", 32'(unalign), 1);
    chk("unal_stall", 32'(stall), 0);
    step(); #1;
    chk("unal_cyc", 32'(wbm_cyc_o), 0);
    chk("unal_flag2", 32'(unalign), 1);

    // bus error on beat 2
    slv_base = 32'hD0; err_en = 1'b1; err_beat = 2'd2;
    addr = 32'h200; #1;
    chk("err_c0_stall", 32'(stall), 1);
    step(); #1;
    step(); #1;
    step(); #1;
    chk("err_beat_addr", wbm_addr_o, 32'h208);
    chk("err_beat_cyc", 32'(wbm_cyc_o), 1);
    step(); #1;
    chk("err_cyc_drop", 32'(wbm_cyc_o), 0);
    chk("err_flag", 32'(bus_err), 1);
    chk("err_stall", 32'(stall), 0);
    step(); #1;
    chk("err_flag_hold", 32'(bus_err), 1);
    chk("err_stall_hold", 32'(stall), 0);
    err_en = 1'b0;
    addr = 32'h300;
    step(); #1;
    chk("err_clear", 32'(bus_err), 0);
    chk("err_next_miss", 32'(stall), 1);
    fetch(32'h300, -1, s);
    chk("after_err_stalls", s, 5);
    fetch(32'h200, -1, s);
    chk("err_line_remiss", s, 5);
    chk("err_line_dout", dout, 32'hD0);

    // invalidate while idle
    step();
    en = 1'b0; inv = 1'b1;
    step();
    inv = 1'b0;
    fetch(32'h300, -1, s);
    chk("inv_idle_300", s, 5);
    fetch(32'h200, -1, s);
    chk("inv_idle_200", s, 5);

    // invalidate mid-refill and on the last-beat ack
    slv_base = 32'hE0;
    fetch(32'h100, 2, s);
    chk("inv_mid_stalls", s, 10);
    chk("inv_mid_dout", dout, 32'hE0);
    fetch(32'h500, 4, s);
    chk("inv_last_stalls", s, 10);
    chk("inv_last_dout", dout, 32'hE0);

    // lock holds outputs and starts nothing
    addr = 32'h504; #1;
    chk("pre_lock_dout", dout, 32'hE1);
    step();
    lock = 1'b1; addr = 32'h700; #1;
    chk("lock_dout", dout, 32'hE1);
    chk("lock_stall", 32'(stall), 0);
    step(); #1;
    chk("lock_nobus", 32'(wbm_cyc_o), 0);
    chk("lock_dout2", dout, 32'hE1);
    step(); #1;
    chk("lock_nobus2", 32'(wbm_cyc_o), 0);
    lock = 1'b0;
    fetch(32'h700, -1, s);
    chk("unlock_stalls", s, 5);
    chk("unlock_dout", dout, 32'hE0);

    // wait states: ack every other cycle
    slow = 1'b1; slv_base = 32'hF0;
    fetch(32'h900, -1, s);
    chk("wait_stalls", s, 9);
    chk("wait_dout", dout, 32'hF0);
    slow = 1'b0;

    // reset during beat 1
    addr = 32'hD00; #1;
    step(); #1;
    step(); #1;
    chk("rst_mid_beat1", wbm_addr_o, 32'hD04);
    rst = 1'b1; en = 1'b0;
    step(); #1;
    chk("rst_mid_cyc", 32'(wbm_cyc_o), 0);
    chk("rst_mid_stb", 32'(wbm_stb_o), 0);
    chk("rst_mid_wbaddr", wbm_addr_o, 0);
    chk("rst_mid_stall", 32'(stall), 0);
    chk("rst_mid_buserr", 32'(bus_err), 0);
    chk("rst_mid_dout", dout, 0);
    rst = 1'b0;
    step();
    fetch(32'hD00, -1, s);
    chk("rst_partial_miss", s, 5);
    chk("rst_partial_dout", dout, 32'hF0);
    fetch(32'h904, -1, s);
    chk("rst_cleared_miss", s, 5);
    chk("rst_cleared_dout", dout, 32'hF1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
